regfile_wb_sched: RTL and testbench

Write-back scheduler for the 2-read/1-write register-file memory in the mips32 benchmark. It shares the single write port between two requesters: port 0 is ALU write-back and port 1 is load write-back. Each requester uses a valid/ready handshake, and arbitration is round-robin. The block registers the winning write onto the memory's write port and provides a read bypass, so the register-file reads in the same cycle as the registered write return the new data.

---
 rtl/mips32_pkg.sv | 24 ++
 rtl/rr_arb2.sv | 52 +++++
 rtl/regfile_wb_sched.sv | 116 +++++++++++
 tb/tb_regfile_wb_sched.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mips32_pkg.sv
// Shared register-file types and constants for the mips32 write-back path.
// Typedefs are sized for the default geometry; modules re-derive widths from their own parameters.
package mips32_pkg;

  localparam int ADDR_SIZE_DEF = 4;
  localparam int BYTE_SIZE_DEF = 8;

  typedef logic [ADDR_SIZE_DEF-1:0] reg_addr_t;
  typedef logic [BYTE_SIZE_DEF-1:0] reg_data_t;

  localparam reg_addr_t ZERO_REG  = 4'd0;
  localparam logic      PORT_ALU  = 1'b0;
  localparam logic      PORT_LOAD = 1'b1;

  // One-hot grant vector for the port named by a round-robin pointer.
  function automatic logic [1:0] port_onehot(input logic port);
    if (port == PORT_LOAD) begin
      return 2'b10;
    end else begin
      return 2'b01;
    end
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: pointer names the preferred port when both request,
// and moves to the other port after every grant.
module rr_arb2
  import mips32_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       stall,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic rr_q;
  logic rr_d;

  // Grant decode; readys stay low while reset is asserted.
  always_comb begin
    gnt = 2'b00;
    if (!reset_n || stall) begin
      gnt = 2'b00;
    end else begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = port_onehot(rr_q);
        default: gnt = 2'b00;
      endcase
    end
  end

  // Pointer advances past the winner; idle cycles leave it alone.
  always_comb begin
    rr_d = rr_q;
    if (gnt[PORT_ALU]) begin
      rr_d = PORT_LOAD;
    end else if (gnt[PORT_LOAD]) begin
      rr_d = PORT_ALU;
    end else begin
      rr_d = rr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_q <= PORT_ALU;
    end else begin
      rr_q <= rr_d;
    end
  end

endmodule

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler: arbitrates ALU and load write-back onto the single register-file
// write port, registers the winner, and bypasses the registered write onto both read ports.
module regfile_wb_sched
  import mips32_pkg::*;
#(
  parameter int ADDR_SIZE     = ADDR_SIZE_DEF,
  parameter int BYTE_SIZE     = BYTE_SIZE_DEF,
  parameter bit HARDWIRE_ZERO = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 stall,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [ADDR_SIZE-1:0] req0_addr,
  input  logic [BYTE_SIZE-1:0] req0_data,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [ADDR_SIZE-1:0] req1_addr,
  input  logic [BYTE_SIZE-1:0] req1_data,
  output logic                 wen,
  output logic [ADDR_SIZE-1:0] waddr,
  output logic [BYTE_SIZE-1:0] wdata,
  input  logic [ADDR_SIZE-1:0] raddr1,
  input  logic [BYTE_SIZE-1:0] mem_rdata1,
  output logic [BYTE_SIZE-1:0] rdata1,
  input  logic [ADDR_SIZE-1:0] raddr2,
  input  logic [BYTE_SIZE-1:0] mem_rdata2,
  output logic [BYTE_SIZE-1:0] rdata2,
  output logic                 busy
);

  localparam logic [ADDR_SIZE-1:0] ZERO_ADDR = ADDR_SIZE'(ZERO_REG);

  logic [1:0]           gnt;
  logic                 wen_q,   wen_d;
  logic [ADDR_SIZE-1:0] waddr_q, waddr_d;
  logic [BYTE_SIZE-1:0] wdata_q, wdata_d;
  logic [ADDR_SIZE-1:0] sel_addr;
  logic [BYTE_SIZE-1:0] sel_data;

  rr_arb2 u_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .stall   (stall),
    .req     ({req1_valid, req0_valid}),
    .gnt     (gnt)
  );

  assign req0_ready = gnt[PORT_ALU];
  assign req1_ready = gnt[PORT_LOAD];

  // Next write-port state; a write to $zero still updates addr/data but never raises wen.
  always_comb begin
    sel_addr = req0_addr;
    sel_data = req0_data;
    wen_d    = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    if (gnt[PORT_LOAD]) begin
      sel_addr = req1_addr;
      sel_data = req1_data;
    end else begin
      sel_addr = req0_addr;
      sel_data = req0_data;
    end
    if (gnt != 2'b00) begin
      waddr_d = sel_addr;
      wdata_d = sel_data;
      wen_d   = !(HARDWIRE_ZERO && (sel_addr == ZERO_ADDR));
    end else begin
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      wen_d   = 1'b0;
    end
  end

  // Registered write port; reset drops any write in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign wen   = wen_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;
  assign busy  = wen_q;

  // Read bypass: $zero reads as 0, otherwise the pending write beats stale memory data.
  always_comb begin
    rdata1 = mem_rdata1;
    rdata2 = mem_rdata2;
    if (HARDWIRE_ZERO && (raddr1 == ZERO_ADDR)) begin
      rdata1 = '0;
    end else if (wen_q && (raddr1 == waddr_q)) begin
      rdata1 = wdata_q;
    end else begin
      rdata1 = mem_rdata1;
    end
    if (HARDWIRE_ZERO && (raddr2 == ZERO_ADDR)) begin
      rdata2 = '0;
    end else if (wen_q && (raddr2 == waddr_q)) begin
      rdata2 = wdata_q;
    end else begin
      rdata2 = mem_rdata2;
    end
  end

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed plus randomized bench for regfile_wb_sched against an architectural register model.
module tb_regfile_wb_sched;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       stall = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [3:0] req0_addr = 4'd0, req1_addr = 4'd0;
  logic [7:0] req0_data = 8'd0, req1_data = 8'd0;
  logic       wen, busy;
  logic [3:0] waddr;
  logic [7:0] wdata;
  logic [3:0] raddr1 = 4'd0, raddr2 = 4'd0;
  logic [7:0] mem_rdata1, mem_rdata2, rdata1, rdata2;

  logic [7:0] mem  [16];
  logic [7:0] arch [16];
  int         turn;
  logic       m_wen;
  logic [3:0] m_waddr;
  logic [7:0] m_wdata;
  int         tests = 0;
  int         fails = 0;

  regfile_wb_sched dut (
    .clock(clock), .reset_n(reset_n), .stall(stall),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
    .wen(wen), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .mem_rdata1(mem_rdata1), .rdata1(rdata1),
    .raddr2(raddr2), .mem_rdata2(mem_rdata2), .rdata2(rdata2),
    .busy(busy)
  );

  always #5 clock = ~clock;

  // External register-file memory, written by the DUT's write port.
  always @(posedge clock) begin
    if (wen) mem[waddr] <= wdata;
  end
  assign mem_rdata1 = mem[raddr1];
  assign mem_rdata2 = mem[raddr2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_read(input logic [3:0] a);
    return (a == 4'd0) ? 8'h00 : arch[a];
  endfunction

  task automatic model_reset();
    turn    = 0;
    m_wen   = 1'b0;
    m_waddr = 4'd0;
    m_wdata = 8'd0;
  endtask

  // One clock of stimulus: drive, check at negedge, advance the model at posedge.
  task automatic cycle(input logic v0, input logic [3:0] a0, input logic [7:0] d0,
                       input logic v1, input logic [3:0] a1, input logic [7:0] d1,
                       input logic st, input logic [3:0] r1, input logic [3:0] r2,
                       output int g);
    logic [3:0] a;
    logic [7:0] d;
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    stall = st; raddr1 = r1; raddr2 = r2;
    if (st) g = -1;
    else if (v0 && v1) g = turn;
    else if (v0) g = 0;
    else if (v1) g = 1;
    else g = -1;
    @(negedge clock);
    chk("req0_ready", req0_ready, g == 0);
    chk("req1_ready", req1_ready, g == 1);
    chk("wen", wen, m_wen);
    chk("busy", busy, m_wen);
    chk("waddr", waddr, m_waddr);
    chk("wdata", wdata, m_wdata);
    chk("rdata1", rdata1, exp_read(r1));
    chk("rdata2", rdata2, exp_read(r2));
    @(posedge clock);
    if (g >= 0) begin
      a = (g == 1) ? a1 : a0;
      d = (g == 1) ? d1 : d0;
      m_waddr = a;
      m_wdata = d;
      m_wen   = (a != 4'd0);
      if (a != 4'd0) arch[a] = d;
      turn = 1 - g;
    end else begin
      m_wen = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1; stall = 1'b0;
    #2;
    chk("rst_req0_ready", req0_ready, 1'b0);
    chk("rst_req1_ready", req1_ready, 1'b0);
    chk("rst_wen", wen, 1'b0);
    chk("rst_waddr", waddr, 4'd0);
    chk("rst_wdata", wdata, 8'd0);
    chk("rst_busy", busy, 1'b0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    model_reset();
  endtask

  initial begin
    int         g;
    logic       p0, p1, st;
    logic [3:0] pa0, pa1;
    logic [7:0] pd0, pd1;
    for (int i = 0; i < 16; i++) begin
      mem[i]  = 8'h00;
      arch[i] = 8'h00;
    end
    mem[0] = 8'hFF;
    model_reset();
    do_reset();

    // Single ALU write after reset.
    cycle(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, 1'b0, 4'd1, 4'd2, g);
    cycle(1'b1, 4'd3, 8'hA5, 1'b0, 4'd0, 8'h00, 1'b0, 4'd3, 4'd0, g);
    chk("t1_grant", g, 0);
    chk("t1_wen", wen, 1'b1);
    chk("t1_waddr", waddr, 4'd3);
    chk("t1_wdata", wdata, 8'hA5);
    cycle(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, 1'b0, 4'd3, 4'd3, g);

    // Alternating grants from reset with both ports busy.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 4'd1, 8'h11, 1'b1, 4'd2, 8'h22, 1'b0, 4'd1, 4'd2, g);
      chk("alt_grant", g, i % 2);
      chk("alt_waddr", waddr, (i % 2 == 0) ? 4'd1 : 4'd2);
    end

    // Same destination: the round-robin loser writes last and wins.
    cycle(1'b1, 4'd5, 8'hAA, 1'b1, 4'd5, 8'hBB, 1'b0, 4'd5, 4'd1, g);
    chk("same_first", g, 0);
    cycle(1'b0, 4'd0, 8'h00, 1'b1, 4'd5, 8'hBB, 1'b0, 4'd5, 4'd2, g);
    chk("same_second", g, 1);
    cycle(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, 1'b0, 4'd5, 4'd5, g);
    cycle(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, 1'b0, 4'd5, 4'd5, g);
    chk("same_final", rdata1, 8'hBB);

    // Bypass of the in-flight write while memory still holds stale data.
    cycle(1'b1, 4'd7, 8'h3C, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 4'd0, g);
    raddr1 = 4'd7; raddr2 = 4'd6;
    #1;
    chk("byp_mem_stale", mem_rdata1, 8'h00);
    chk("byp_rdata1", rdata1, 8'h3C);
    chk("byp_rdata2", rdata2, mem_rdata2);
    cycle(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, 1'b0, 4'd7, 4'd6, g);

    // Hardwired zero: handshake completes, write dropped, reads return 0.
    cycle(1'b0, 4'd0, 8'h00, 1'b1, 4'd0, 8'hFF, 1'b0, 4'd0, 4'd0, g);
    chk("hz_grant", g, 1);
    chk("hz_wen", wen, 1'b0);
    chk("hz_waddr", waddr, 4'd0);
    chk("hz_rdata1", rdata1, 8'h00);
    cycle(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 4'd0, g);

    // Stall blocks new grants but the registered write completes.
    cycle(1'b1, 4'd9, 8'h77, 1'b0, 4'd0, 8'h00, 1'b0, 4'd9, 4'd0, g);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 4'd9, 8'h66, 1'b0, 4'd0, 8'h00, 1'b1, 4'd9, 4'd1, g);
      chk("stall_grant", g, -1);
    end
    cycle(1'b1, 4'd9, 8'h66, 1'b0, 4'd0, 8'h00, 1'b0, 4'd9, 4'd1, g);
    chk("stall_release", g, 0);

    // Randomized traffic; requesters hold their request until accepted.
    p0 = 1'b0; p1 = 1'b0;
    pa0 = 4'd0; pa1 = 4'd0; pd0 = 8'd0; pd1 = 8'd0;
    for (int i = 0; i < 300; i++) begin
      if (!p0 && ($urandom_range(0, 2) != 0)) begin
        p0 = 1'b1; pa0 = 4'($urandom_range(0, 15)); pd0 = 8'($urandom);
      end
      if (!p1 && ($urandom_range(0, 2) != 0)) begin
        p1 = 1'b1; pa1 = ($urandom_range(0, 3) == 0) ? pa0 : 4'($urandom_range(0, 15));
        pd1 = 8'($urandom);
      end
      st = ($urandom_range(0, 4) == 0);
      cycle(p0, pa0, pd0, p1, pa1, pd1, st,
            4'($urandom_range(0, 15)), ($urandom_range(0, 1) == 1) ? m_waddr : 4'($urandom_range(0, 15)), g);
      if (g == 0) p0 = 1'b0;
      if (g == 1) p1 = 1'b0;
    end

    // Asynchronous reset with a write in flight.
    cycle(1'b1, 4'd4, 8'h44, 1'b0, 4'd0, 8'h00, 1'b0, 4'd4, 4'd0, g);
    chk("async_pre_wen", wen, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_wen", wen, 1'b0);
    chk("async_busy", busy, 1'b0);
    chk("async_ready", req0_ready, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
